// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage and the 8-bit decoder.
// Optional feature macro used by this slice: FETCH_CYCLE_COUNT_EN.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam int INSTR_W     = 8;
   localparam int LABEL_IDX_W = 4;

   // Upper-nibble opcodes; the decoder and the fetch stage must agree on these.
   localparam logic [3:0] OP_BEQ0 = 4'hA;
   localparam logic [3:0] OP_J    = 4'hB;
   localparam logic [3:0] OP_STL  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic isControlFlow(input logic [INSTR_W-1:0] instrWord);
      return (instrWord[7:4] == OP_BEQ0) || (instrWord[7:4] == OP_J);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its surroundings (imem, decoder, execute).
// cycleCnt exists only when FETCH_CYCLE_COUNT_EN is defined.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = 8
`ifdef FETCH_CYCLE_COUNT_EN
 , parameter int CNT_W = 32
`endif
);

   logic                   start;
   logic [PC_W-1:0]        imemAddr;
   logic [INSTR_W-1:0]     imemData;
   logic [INSTR_W-1:0]     instr;
   logic                   instrValid;
   logic                   labelRead;
   logic                   branchCond;
   logic                   labelWrite;
   logic [LABEL_IDX_W-1:0] labelIdx;
   logic                   halt;
   logic [PC_W-1:0]        pc;
   logic                   done;

`ifdef FETCH_CYCLE_COUNT_EN
   logic [CNT_W-1:0]       cycleCnt;

   modport master (
      input  start, imemData, labelRead, branchCond, labelWrite, labelIdx, halt,
      output imemAddr, instr, instrValid, pc, done, cycleCnt
   );

   modport slave (
      output start, imemData, labelRead, branchCond, labelWrite, labelIdx, halt,
      input  imemAddr, instr, instrValid, pc, done, cycleCnt
   );
`else
   modport master (
      input  start, imemData, labelRead, branchCond, labelWrite, labelIdx, halt,
      output imemAddr, instr, instrValid, pc, done
   );

   modport slave (
      output start, imemData, labelRead, branchCond, labelWrite, labelIdx, halt,
      input  imemAddr, instr, instrValid, pc, done
   );
`endif

endinterface

// File: rtl/fetch_unit_label_table.sv
// Label table: branch targets recorded by label-store instructions.
// One write port, one asynchronous read port, cleared by synchronous reset.
module label_table #(
   parameter int LABELS = 16,
   parameter int PC_W   = 8,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             writeEn,
   input  logic [IDX_W-1:0] writeIdx,
   input  logic [PC_W-1:0]  writeData,
   input  logic [IDX_W-1:0] readIdx,
   output logic [PC_W-1:0]  readData
);

   logic [PC_W-1:0] entries [LABELS];

   // Reads see the pre-edge contents, so a same-cycle write is invisible until next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < LABELS; i++) begin
            entries[i] <= '0;
         end
      end else if (writeEn) begin
         entries[writeIdx] <= writeData;
      end
   end

   assign readData = entries[readIdx];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem addressing, label-table branch resolution, run/halt sequencing.
// FETCH_CYCLE_COUNT_EN adds a saturating retired-instruction counter on bus.cycleCnt.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int LABELS = 16
`ifdef FETCH_CYCLE_COUNT_EN
 , parameter int CNT_W  = 32
`endif
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   fetch_state_t    state;
   fetch_state_t    stateNext;
   logic [PC_W-1:0] pcReg;
   logic [PC_W-1:0] pcNext;
   logic [PC_W-1:0] pcInc;
   logic [PC_W-1:0] labelData;
   logic            runActive;
   logic            labelWe;

   assign pcInc = pcReg + PC_W'(1);

   label_table #(
      .LABELS (LABELS),
      .PC_W   (PC_W),
      .IDX_W  (LABEL_IDX_W)
   ) uLabelTable (
      .clk       (clk),
      .rst_n     (rst_n),
      .writeEn   (labelWe),
      .writeIdx  (bus.labelIdx),
      .writeData (pcInc),
      .readIdx   (bus.labelIdx),
      .readData  (labelData)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pcReg <= '0;
      end else begin
         state <= stateNext;
         pcReg <= pcNext;
      end
   end

   // Decoder controls only matter in RUN; elsewhere the PC is frozen until a start.
   always_comb begin
      stateNext = state;
      pcNext    = pcReg;
      runActive = 1'b0;
      labelWe   = 1'b0;
      case (state)
         IDLE, HALTED: begin
            if (bus.start) begin
               stateNext = RUN;
               pcNext    = '0;
            end
         end
         RUN: begin
            runActive = 1'b1;
            labelWe   = bus.labelWrite;
            if (bus.halt) begin
               stateNext = HALTED;
            end else if (bus.labelRead && bus.branchCond) begin
               pcNext = labelData;
            end else begin
               pcNext = pcInc;
            end
         end
         default: begin
            stateNext = IDLE;
            pcNext    = '0;
         end
      endcase
   end

`ifdef FETCH_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cntReg;

   // Counts every valid cycle including the halt itself, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cntReg <= '0;
      end else if ((state != RUN) && bus.start) begin
         cntReg <= '0;
      end else if (runActive && (cntReg != '1)) begin
         cntReg <= cntReg + CNT_W'(1);
      end
   end

   assign bus.cycleCnt = cntReg;
`endif

   assign bus.imemAddr   = pcReg;
   assign bus.pc         = pcReg;
   assign bus.instrValid = runActive;
   assign bus.instr      = runActive ? bus.imemData : '0;
   assign bus.done       = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of controls with expected next-cycle outputs fed
// through a scoreboard queue, plus hand sequences for reset, restart and PC wrap.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   typedef struct {
      logic        start;
      logic        labelRead;
      logic        branchCond;
      logic        labelWrite;
      logic [3:0]  idx;
      logic        halt;
      logic [7:0]  expPc;
      logic        expValid;
      logic        expDone;
      int unsigned expCnt;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fetch_unit_if #(.PC_W(8)) busA ();
   fetch_unit_if #(.PC_W(4)) busB ();

   fetch_unit #(.PC_W(8), .LABELS(16)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
   fetch_unit #(.PC_W(4), .LABELS(16)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

   logic [7:0] memA [256];
   logic [7:0] memB [16];

   assign busA.imemData = memA[busA.imemAddr];
   assign busB.imemData = memB[busB.imemAddr];

   vec_t sbq [$];
   vec_t tbl [$];
   int   checks = 0;
   int   passed = 0;

   function automatic vec_t mk(input logic st, input logic lr, input logic bc, input logic lw,
                               input logic [3:0] idx, input logic h, input logic [7:0] pc,
                               input logic v, input logic d, input int unsigned cnt);
      vec_t r;
      r.start = st; r.labelRead = lr; r.branchCond = bc; r.labelWrite = lw;
      r.idx = idx; r.halt = h; r.expPc = pc; r.expValid = v; r.expDone = d; r.expCnt = cnt;
      return r;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic checkOutput(input string tag);
      vec_t v;
      if (sbq.size() == 0) begin
         checkVal({tag, ".scoreboard"}, 32'd0, 32'd1);
         return;
      end
      v = sbq.pop_front();
      checkVal({tag, ".pc"}, 32'(busA.pc), 32'(v.expPc));
      checkVal({tag, ".imemAddr"}, 32'(busA.imemAddr), 32'(v.expPc));
      checkVal({tag, ".valid"}, 32'(busA.instrValid), 32'(v.expValid));
      checkVal({tag, ".done"}, 32'(busA.done), 32'(v.expDone));
      checkVal({tag, ".instr"}, 32'(busA.instr), v.expValid ? 32'(memA[v.expPc]) : 32'd0);
`ifdef FETCH_CYCLE_COUNT_EN
      checkVal({tag, ".cnt"}, busA.cycleCnt, v.expCnt);
`endif
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      busA.start      = v.start;
      busA.labelRead  = v.labelRead;
      busA.branchCond = v.branchCond;
      busA.labelWrite = v.labelWrite;
      busA.labelIdx   = v.idx;
      busA.halt       = v.halt;
      sbq.push_back(v);
      @(posedge clk);
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) memA[i] = 8'((i * 7) + 3);
      for (int i = 0; i < 16; i++) memB[i] = 8'(i + 8'h40);
      busB.start = 0; busB.labelRead = 0; busB.branchCond = 0;
      busB.labelWrite = 0; busB.labelIdx = 0; busB.halt = 0;

      // Reset state
      rst_n = 1'b0;
      applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0), "reset0");
      applyStimulus(mk(1,0,0,0,0,0, 0,0,0,0), "reset1");
      rst_n = 1'b1;

      // Main table: each row's controls, then the expected outputs one cycle later
      tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
      for (int k = 1; k <= 5; k++) tbl.push_back(mk(0,0,0,0,0,0, 8'(k),1,0,k));
      tbl.push_back(mk(0,0,0,1,3,0, 6,1,0,6));
      for (int k = 7; k <= 9; k++) tbl.push_back(mk(0,0,0,0,0,0, 8'(k),1,0,k));
      tbl.push_back(mk(0,1,1,0,3,0, 6,1,0,10));
      for (int k = 7; k <= 9; k++) tbl.push_back(mk(0,0,0,0,0,0, 8'(k),1,0,k + 4));
      tbl.push_back(mk(0,1,0,0,3,0, 10,1,0,14));
      tbl.push_back(mk(0,1,1,0,12,0, 0,1,0,15));
      tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,16));
      tbl.push_back(mk(0,0,0,1,4,0, 2,1,0,17));
      tbl.push_back(mk(0,1,1,1,4,0, 2,1,0,18));
      tbl.push_back(mk(0,1,1,0,4,0, 3,1,0,19));
      tbl.push_back(mk(0,0,0,0,0,1, 3,0,1,20));
      tbl.push_back(mk(0,1,1,1,3,1, 3,0,1,20));
      tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
      for (int k = 1; k <= 7; k++) tbl.push_back(mk(0,0,0,0,0,0, 8'(k),1,0,k));
      tbl.push_back(mk(0,0,0,0,0,1, 7,0,1,8));
      tbl.push_back(mk(0,0,0,0,0,0, 7,0,1,8));
      tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
      tbl.push_back(mk(0,1,1,0,3,0, 6,1,0,1));
      for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("t%0d", i));

      // Walk to PC 20 with start pulses that must be ignored
      for (int k = 7; k <= 20; k++)
         applyStimulus(mk(1'(k % 2),0,0,0,0,0, 8'(k),1,0,k - 5), $sformatf("walk%0d", k));

      // Mid-run reset beats a start, a label write and a taken branch
      rst_n = 1'b0;
      applyStimulus(mk(1,1,1,1,3,0, 0,0,0,0), "midReset");
      rst_n = 1'b1;
      applyStimulus(mk(0,1,1,1,3,1, 0,0,0,0), "idleIgnore");
      applyStimulus(mk(1,0,0,0,0,0, 0,1,0,0), "restart");
      applyStimulus(mk(0,1,1,0,3,0, 0,1,0,1), "cleared3");
      applyStimulus(mk(0,1,1,0,4,0, 0,1,0,2), "cleared4");
      busA.start = 0; busA.labelRead = 0; busA.branchCond = 0;
      busA.labelWrite = 0; busA.halt = 0;

      // Narrow PC wraps 15 -> 0 silently
      busB.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busB.start = 1'b0;
      checkVal("wrap.pc0", 32'(busB.pc), 32'd0);
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkVal($sformatf("wrap.pc%0d", i), 32'(busB.pc), 32'(i % 16));
         checkVal($sformatf("wrap.done%0d", i), 32'(busB.done), 32'd0);
         checkVal($sformatf("wrap.instr%0d", i), 32'(busB.instr), 32'(memB[i % 16]));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
